// File: rtl/fnd_scan_ctrl.sv
// Converts the software value register to BCD (double dabble, 16 cycles change-to-latch) and scans it onto a 4-digit common-anode display.
// Latency: one registered stage from digit index/latch to pins; no backpressure, value changes arriving mid-conversion are picked up afterwards.
module fnd_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int VALUE_W  = 14
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] ctrl_reg,
    input  logic [31:0] value_reg,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_font,
    output logic        busy,
    output logic        ovf
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t             state;
    logic [VALUE_W-1:0] last_val;
    logic [VALUE_W-1:0] bin;
    logic [15:0]        bcd;
    logic [3:0]         iter;
    logic               ovf_pend;
    logic [15:0]        disp;
    logic [CNT_W-1:0]   scan_cnt;
    logic [1:0]         idx;

    logic [VALUE_W-1:0] cur_val;
    logic               sat;
    logic [15:0]        bcd_adj;
    logic [15:0]        bcd_next;
    logic [VALUE_W-1:0] bin_next;
    logic [3:0]         digit;
    logic               blank;
    logic [3:0]         dp_mask;
    logic [7:0]         font_next;
    logic               unused_bits;

    assign cur_val     = value_reg[VALUE_W-1:0];
    assign sat         = (cur_val > VALUE_W'(9999));
    assign dp_mask     = ctrl_reg[7:4];
    assign unused_bits = ^{ctrl_reg[31:8], ctrl_reg[3:2], value_reg[31:VALUE_W]};

    // Double-dabble step: correct every nibble >= 5 before shifting the next binary bit in.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[14:0], bin[VALUE_W-1]};
        bin_next = {bin[VALUE_W-2:0], 1'b0};
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state    <= IDLE;
            last_val <= '0;
            bin      <= '0;
            bcd      <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
            disp     <= '0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cur_val != last_val) begin
                        last_val <= cur_val;
                        bin      <= sat ? VALUE_W'(9999) : cur_val;
                        ovf_pend <= sat;
                        bcd      <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= bcd_next;
                    bin  <= bin_next;
                    iter <= iter + 4'd1;
                    if (iter == 4'(VALUE_W - 1)) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    disp  <= bcd;
                    ovf   <= ovf_pend;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is blank only if it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        digit = disp[3:0];
        blank = 1'b0;
        case (idx)
            2'd0: digit = disp[3:0];
            2'd1: begin
                digit = disp[7:4];
                blank = (disp[15:4] == 12'd0);
            end
            2'd2: begin
                digit = disp[11:8];
                blank = (disp[15:8] == 8'd0);
            end
            default: begin
                digit = disp[15:12];
                blank = (disp[15:12] == 4'd0);
            end
        endcase
        font_next = {~dp_mask[idx], (ctrl_reg[1] && blank) ? 7'h7F : seg7(digit)};
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            fnd_com  <= 4'b1111;
            fnd_font <= 8'hFF;
        end else if (ctrl_reg[0]) begin
            fnd_com  <= ~(4'b0001 << idx);
            fnd_font <= font_next;
        end else begin
            fnd_com  <= 4'b1111;
            fnd_font <= 8'hFF;
        end
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Downstream consumer of the AXI4-Lite register bank in the MicroBlaze FND IP. It takes the control and value registers written by software and converts the binary value to 4-digit BCD with a sequential double-dabble engine. It then time-multiplexes the digits onto a common-anode 4-digit 7-segment display. All outputs drive FPGA pins directly.

Parameters:
SCAN_DIV, 100000, ACLK cycles each digit is held (1 kHz per digit at 100 MHz); minimum 2
VALUE_W, 14, width of binary value taken from value_reg[VALUE_W-1:0]; fixed at 14 (max 16383)

Ports:
ACLK  in  1  system clock, all logic rising-edge
ARESETN  in  1  synchronous active-low reset
ctrl_reg  in  32  bit0 display enable, bit1 leading-zero blanking, bits[7:4] decimal-point mask (bit4 = digit0/rightmost); other bits ignored
value_reg  in  32  binary value to display, bits[13:0] used, bits[31:14] ignored
fnd_com  out  4  digit select, active-low, bit0 = rightmost digit
fnd_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
busy  out  1  high while a BCD conversion is in progress
ovf  out  1  high while the displayed value was saturated (input > 9999)

Behaviour:
- Reset (ARESETN=0 at a rising edge): fnd_com=4'b1111, fnd_font=8'hFF, busy=0, ovf=0, BCD display latch=0000, digit index=0, scan counter=0, FSM=IDLE, last-value register=0.
- Change detect: value_reg[13:0] is compared every cycle against the last-value register. If they differ while the FSM is in IDLE, the value is captured, the last-value register is updated, and the FSM enters CONV.
- Saturation: if the captured value > 9999, the conversion operand is 9999 and ovf_pending=1; otherwise ovf_pending=0.
- FSM IDLE -> CONV -> LOAD -> IDLE.
  - CONV: 14 iterations, one per cycle. Each iteration does add-3 on every BCD nibble >= 5, then shifts {bcd,bin} left by 1. busy=1.
  - LOAD: 1 cycle. The 16-bit BCD result is copied to the display latch and ovf<=ovf_pending. busy=1.
  - Latency: the value change is seen on cycle N; busy rises at N+1; the display latch is updated at N+16; busy falls at N+16.
- Changes during CONV/LOAD are not aborted. The change is detected after return to IDLE because the last-value register differs, so the final value is always displayed. Intermediate values may be skipped.
- The display latch changes only in LOAD, so there is no partial or tearing update mid-scan.
- Scan counter: counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the digit index increments 0->1->2->3->0. The scan counter runs regardless of enable.
- Output registers: fnd_com and fnd_font are registered one cycle after the digit index and latch. fnd_com = ~(1<<index).
- Font: hex-to-7seg for nibbles 0-9; abcdefg active-low; e.g. 0 -> 8'hC0 with dp off, 8 -> 8'h80.
- dp: fnd_font[7]=~ctrl_reg[4+index].
- Leading-zero blanking (ctrl_reg[1]=1): a digit at index k>0 is blanked (font 8'hFF, dp still applied) when it and all higher digits are 0. Digit 0 is never blanked, so 0 shows as a single "0".
- Enable=0: fnd_com=4'b1111 and fnd_font=8'hFF on the next cycle. Conversion still runs; the latch keeps tracking the value.
- Reset mid-conversion: the FSM returns to IDLE and the latch clears. Because the last-value register is 0, after reset any nonzero value_reg triggers a conversion.

Test Plan:
- Reset, SCAN_DIV=4, ctrl_reg=1, value_reg=1234 -> busy is high for exactly 15 cycles starting 1 cycle after reset deassert. The scan then cycles com 1110/1101/1011/0111 every 4 cycles with fonts 8'h99(4), 8'hB0(3), 8'hA4(2), 8'hF9(1); ovf=0.
- value_reg=12000 -> display 9999 (all digits 8'h90), ovf=1. Then value_reg=5 -> ovf=0 after LOAD.
- ctrl_reg=32'h3 (blanking on), value_reg=7 -> digit0 8'hF8, digits1-3 8'hFF. With value_reg=0 -> digit0 8'hC0, others 8'hFF.
- ctrl_reg=32'h31 (dp on digits 0,1), value_reg=4321 -> digit0 font 8'h79, digit1 font 8'h24, digits2/3 with dp bit=1.
- Write 1111, then 2222 two cycles later, during CONV -> no abort. The latch shows 1111 briefly, then 2222; busy re-asserts within 1 cycle of the first LOAD.
- Enable toggled to 0 mid-scan -> com=1111, font=FF next cycle. ARESETN low during CONV -> all outputs at reset values on the next edge; after release the nonzero value is reconverted.
